instr_fetch_mem: RTL and testbench

//  Parametrised word-addressed instruction memory with a registered read port and valid/ready fetch/response handshakes.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_array.sv | 29 ++
 rtl/instr_fetch_mem.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_mem.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction fetch memory.
package imem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int WORD_BYTES = 4;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module imem_array
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with fetch/response handshakes, program-load port and post-reset clear sweep.
// Build option: define IMEM_ALIGN_CHECK_EN to fault fetches whose byte address is not word aligned.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              init_done
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam int LSB   = $clog2(WORD_BYTES);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  cnt_reg, cnt_next;

    logic              rsp_valid_reg;
    logic [ADDR_W-1:0] rsp_addr_reg;
    logic              rsp_fault_reg;
    logic              rsp_zero_reg;

    logic              run;
    logic              accept;
    logic              load_fire;
    logic              req_oob;
    logic              ld_oob;
    logic              req_misalign;
    logic              req_fault;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  ld_idx;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    // Whole-vector shifts: anything above the word index means out of range.
    assign req_oob = (req_addr >> (IDX_W + LSB)) != '0;
    assign ld_oob  = (ld_addr  >> (IDX_W + LSB)) != '0;
    assign req_idx = req_addr[IDX_W+LSB-1:LSB];
    assign ld_idx  = ld_addr[IDX_W+LSB-1:LSB];

`ifdef IMEM_ALIGN_CHECK_EN
    assign req_misalign = req_addr[LSB-1:0] != '0;
`else
    assign req_misalign = 1'b0;
`endif

    assign req_fault = req_oob || req_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_INIT) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == IDX_W'(DEPTH - 1)) begin
                state_next = ST_RUN;
            end
        end
    end

    // A reset cycle never accepts work even though the state flop still reads RUN.
    assign run       = (state_reg == ST_RUN) && !rst;
    assign req_ready = run && !ld_en && (!rsp_valid_reg || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign load_fire = run && ld_en && !ld_oob;
    assign init_done = (state_reg == ST_RUN);

    // The sweep owns the write port during INIT; afterwards the load path does.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ld_idx;
        wr_data = ld_data;
        if (state_reg == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_reg;
            wr_data = '0;
        end else if (load_fire) begin
            wr_en = 1'b1;
        end
    end

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_idx  (req_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_addr_reg  <= '0;
            rsp_fault_reg <= 1'b0;
            rsp_zero_reg  <= 1'b1;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_addr_reg  <= req_addr;
            rsp_fault_reg <= req_fault;
            rsp_zero_reg  <= req_fault;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    // The read register only moves on accept, so masking it here keeps stalled data stable.
    assign rsp_data  = rsp_zero_reg ? '0 : rd_data;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_addr  = rsp_addr_reg;
    assign rsp_fault = rsp_fault_reg;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Randomised plus directed bench for instr_fetch_mem against a cycle-level behavioural model.
module tb_instr_fetch_mem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_fault;
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              init_done;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: memory image, cycles since reset, and the one outstanding response.
    logic [DATA_W-1:0] mem_model [DEPTH];
    int                since = 0;
    bit                exp_valid = 1'b0;
    logic [DATA_W-1:0] exp_data = '0;
    logic [ADDR_W-1:0] exp_addr = '0;
    bit                exp_fault = 1'b0;

`ifdef IMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .init_done (init_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(DEPTH * 4);
    endfunction

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic cycle();
        bit run, rdy, acc, ldf, flt;
        @(negedge clk);
        run = (since >= DEPTH) && !rst;
        rdy = run && !ld_en && (!exp_valid || rsp_ready);
        check("req_ready", 32'(req_ready), 32'(rdy));
        check("init_done", 32'(init_done), 32'(since >= DEPTH));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("rsp_data", rsp_data, exp_data);
            check("rsp_addr", rsp_addr, exp_addr);
            check("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
        end
        acc = req_valid && rdy;
        ldf = run && ld_en && in_range(ld_addr);
        if (rst) begin
            since     = 0;
            exp_valid = 1'b0;
            foreach (mem_model[i]) mem_model[i] = '0;
        end else begin
            if (exp_valid && rsp_ready)
                $display("rsp addr=%h data=%h fault=%0d", exp_addr, exp_data, exp_fault);
            if (since < DEPTH) since++;
            if (acc) begin
                flt       = !in_range(req_addr) || (ALIGN_CHK && req_addr[1:0] != 2'b00);
                exp_valid = 1'b1;
                exp_addr  = req_addr;
                exp_fault = flt;
                exp_data  = flt ? '0 : mem_model[(req_addr / 4) % DEPTH];
            end else if (rsp_ready) begin
                exp_valid = 1'b0;
            end
            if (ldf) mem_model[(ld_addr / 4) % DEPTH] = ld_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic wait_init();
        for (int i = 0; i < DEPTH + 4 && since < DEPTH; i++) cycle();
        check("init_reached", 32'(init_done), 32'd1);
    endtask

    initial begin
        logic [DATA_W-1:0] held;

        // First edge establishes reset state; model starts from there.
        @(posedge clk);
        #1;
        foreach (mem_model[i]) mem_model[i] = '0;
        cycle();
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_addr", rsp_addr, 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        idle();
        wait_init();

        // Program load then back-to-back fetches.
        ld_en = 1'b1; ld_addr = 32'd100; ld_data = 32'h8C220000; cycle();
        ld_addr = 32'd104; ld_data = 32'h8C230004; cycle();
        ld_en = 1'b0; req_valid = 1'b1; req_addr = 32'd100; cycle();
        check("fetch100", rsp_data, 32'h8C220000);
        req_addr = 32'd104; cycle();
        check("fetch104", rsp_data, 32'h8C230004);
        check("fetch104_fault", 32'(rsp_fault), 32'd0);

        // Stall for three cycles with a request waiting.
        rsp_ready = 1'b0; req_addr = 32'd100; held = rsp_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_data", rsp_data, held);
        end
        rsp_ready = 1'b1; cycle();
        check("after_stall", rsp_data, 32'h8C220000);
        req_valid = 1'b0; cycle();

        // Faulting fetches.
        req_valid = 1'b1; req_addr = 32'h400; cycle();
        check("oob_fault", 32'(rsp_fault), 32'd1);
        check("oob_data", rsp_data, 32'd0);
        req_addr = 32'h66; cycle();
        check("mis_fault", 32'(rsp_fault), 32'(ALIGN_CHK));
        check("mis_data", rsp_data, ALIGN_CHK ? 32'd0 : 32'h8C220000);
        req_valid = 1'b0; cycle();

        // Load and fetch collide: load wins, fetch sees new data next cycle.
        ld_en = 1'b1; ld_addr = 32'd108; ld_data = 32'h8C240008;
        req_valid = 1'b1; req_addr = 32'd108; cycle();
        ld_en = 1'b0; cycle();
        check("raw108", rsp_data, 32'h8C240008);
        req_valid = 1'b0; cycle();

        // Reset while a response is stalled.
        req_valid = 1'b1; req_addr = 32'd100; cycle();
        req_valid = 1'b0; rsp_ready = 1'b0; cycle();
        rst = 1'b1; cycle();
        check("rst_drop", 32'(rsp_valid), 32'd0);
        rst = 1'b0; idle();
        wait_init();
        req_valid = 1'b1; req_addr = 32'd100; cycle();
        check("cleared100", rsp_data, 32'd0);
        idle(); cycle();

        // Random traffic over a small address window with occasional faults and resets.
        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(0, 599) == 0);
            req_valid = ($urandom_range(0, 9) < 6);
            rsp_ready = ($urandom_range(0, 9) < 7);
            ld_en     = ($urandom_range(0, 3) == 0);
            req_addr  = 32'($urandom_range(0, 63));
            ld_addr   = 32'($urandom_range(0, 63));
            ld_data   = $urandom;
            if ($urandom_range(0, 9) == 0) req_addr |= 32'(1) << $urandom_range(10, 31);
            if ($urandom_range(0, 9) == 0) ld_addr  |= 32'(1) << $urandom_range(10, 31);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
